// File: rtl/uart_wb_master.sv
// rtl/uart_wb_master.sv - Wishbone master that polls the Amber UART FR and moves bytes via DR
// Optional ack timeout abort enabled by defining UART_WBM_TIMEOUT_EN.
module uart_wb_master #(
  parameter logic [31:0] UART_BASE = 32'h1600_0000,
  parameter int          POLL_GAP  = 16,
  parameter int          TIMEOUT   = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_tx_valid,
  input  logic [7:0]  i_tx_data,
  output logic        o_tx_ready,
  output logic        o_rx_valid,
  output logic [7:0]  o_rx_data,
  input  logic        i_rx_ready,
  output logic [31:0] o_wb_adr,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic [31:0] o_wb_dat,
  input  logic [31:0] i_wb_dat,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  output logic        o_busy,
  output logic        o_error
);

  typedef enum logic [2:0] {IDLE, FR_RD, DECIDE, DR_WR, DR_RD} state_t;

  localparam logic [31:0] FR_ADR = UART_BASE + 32'h0000_0018;
  localparam logic [15:0] GAP    = 16'(POLL_GAP);

  state_t      state;
  logic [15:0] poll_cnt;
  logic [7:0]  tx_hold;
  logic        tx_hold_valid;
  logic        fr_txff;
  logic        fr_rxfe;
  logic        last_tx;
  logic        timeout_hit;
  logic        abort;
  logic        tx_ok;
  logic        rx_ok;
  logic        unused_dat;

  assign o_tx_ready = !tx_hold_valid;
  assign o_wb_stb   = o_wb_cyc;
  assign o_busy     = (state != IDLE);
  assign tx_ok      = tx_hold_valid && !fr_txff;
  assign rx_ok      = !o_rx_valid && !fr_rxfe;
  assign abort      = o_wb_cyc && (i_wb_err || timeout_hit);
  assign unused_dat = ^i_wb_dat[31:8];

`ifdef UART_WBM_TIMEOUT_EN
  logic [31:0] to_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) to_cnt <= '0;
    else       to_cnt <= o_wb_cyc ? to_cnt + 32'd1 : '0;
  end

  assign timeout_hit = (to_cnt == 32'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      poll_cnt      <= '0;
      tx_hold       <= '0;
      tx_hold_valid <= 1'b0;
      fr_txff       <= 1'b0;
      fr_rxfe       <= 1'b0;
      last_tx       <= 1'b0;
      o_rx_valid    <= 1'b0;
      o_rx_data     <= '0;
      o_wb_adr      <= '0;
      o_wb_sel      <= '0;
      o_wb_we       <= 1'b0;
      o_wb_dat      <= '0;
      o_wb_cyc      <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      if (i_tx_valid && !tx_hold_valid) begin
        tx_hold       <= i_tx_data;
        tx_hold_valid <= 1'b1;
      end
      if (o_rx_valid && i_rx_ready) o_rx_valid <= 1'b0;

      // Error or timeout ends the cycle like an ack but leaves both holding registers alone.
      if (abort) begin
        o_error  <= 1'b1;
        o_wb_cyc <= 1'b0;
        o_wb_we  <= 1'b0;
        o_wb_sel <= '0;
        poll_cnt <= GAP;
        state    <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // Leave on the final count so the poll lands POLL_GAP+1 cycles after DECIDE.
            if (poll_cnt > 16'd1) begin
              poll_cnt <= poll_cnt - 16'd1;
            end else begin
              poll_cnt <= '0;
              if (tx_hold_valid || !o_rx_valid) begin
                o_wb_cyc <= 1'b1;
                o_wb_sel <= 4'hf;
                o_wb_we  <= 1'b0;
                o_wb_adr <= FR_ADR;
                o_wb_dat <= '0;
                state    <= FR_RD;
              end
            end
          end
          FR_RD: begin
            if (!o_wb_cyc) begin
              o_wb_cyc <= 1'b1;
              o_wb_sel <= 4'hf;
              o_wb_we  <= 1'b0;
              o_wb_adr <= FR_ADR;
              o_wb_dat <= '0;
            end else if (i_wb_ack) begin
              fr_txff  <= i_wb_dat[5];
              fr_rxfe  <= i_wb_dat[4];
              o_wb_cyc <= 1'b0;
              o_wb_sel <= '0;
              state    <= DECIDE;
            end
          end
          DECIDE: begin
            if (tx_ok && (!rx_ok || !last_tx)) begin
              o_wb_cyc <= 1'b1;
              o_wb_sel <= 4'hf;
              o_wb_we  <= 1'b1;
              o_wb_adr <= UART_BASE;
              o_wb_dat <= {24'h0, tx_hold};
              state    <= DR_WR;
            end else if (rx_ok) begin
              o_wb_cyc <= 1'b1;
              o_wb_sel <= 4'hf;
              o_wb_we  <= 1'b0;
              o_wb_adr <= UART_BASE;
              o_wb_dat <= '0;
              state    <= DR_RD;
            end else begin
              poll_cnt <= GAP;
              state    <= IDLE;
            end
          end
          DR_WR: begin
            if (i_wb_ack) begin
              tx_hold_valid <= 1'b0;
              last_tx       <= 1'b1;
              o_wb_cyc      <= 1'b0;
              o_wb_we       <= 1'b0;
              o_wb_sel      <= '0;
              state         <= FR_RD;
            end
          end
          DR_RD: begin
            if (i_wb_ack) begin
              o_rx_data  <= i_wb_dat[7:0];
              o_rx_valid <= 1'b1;
              last_tx    <= 1'b0;
              o_wb_cyc   <= 1'b0;
              o_wb_sel   <= '0;
              state      <= FR_RD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_wb_master.sv
// tb/tb_uart_wb_master.sv - scoreboard bench for uart_wb_master against a registered-ack UART model
module tb_uart_wb_master;

  localparam int          POLL_GAP = 16;
  localparam int          TIMEOUT  = 256;
  localparam logic [31:0] BASE     = 32'h1600_0000;
  localparam logic [31:0] FR_ADR   = BASE + 32'h18;

  logic        clk;
  logic        rst;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_ack;
  logic        wb_err;
  logic        busy;
  logic        error;

  uart_wb_master #(.UART_BASE(BASE), .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_tx_valid(tx_valid), .i_tx_data(tx_data), .o_tx_ready(tx_ready),
    .o_rx_valid(rx_valid), .o_rx_data(rx_data), .i_rx_ready(rx_ready),
    .o_wb_adr(wb_adr), .o_wb_sel(wb_sel), .o_wb_we(wb_we), .o_wb_dat(wb_dat_o),
    .i_wb_dat(wb_dat_i), .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb),
    .i_wb_ack(wb_ack), .i_wb_err(wb_err), .o_busy(busy), .o_error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  // UART model state and scoreboards
  logic [7:0]  fr_val = 8'h90;
  logic [31:0] dr_val = '0;
  logic        hold_ack = 1'b0;
  logic        err_next_wr = 1'b0;
  logic        seen = 1'b0;
  logic [31:0] start_adr;
  logic [7:0]  mon_exp;
  logic        wr_tx_ready;
  int fr_reads = 0, fr_starts = 0, last_fr_start = 0, fr_ack_cycle = 0;
  int dr_writes = 0, dr_reads = 0, dr_wr_cycle = 0;
  logic [7:0] exp_wr[$];
  logic [7:0] exp_rx[$];
  logic [7:0] op_log[$];

  // Registered-ack slave: ack/err arrive in the second cycle of an access.
  always @(negedge clk) begin
    if (rst) begin
      wb_ack = 1'b0; wb_err = 1'b0; seen = 1'b0;
    end else if (wb_ack || wb_err) begin
      wb_ack = 1'b0; wb_err = 1'b0; seen = 1'b0;
    end else if (!wb_cyc) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      start_adr = wb_adr;
      if (wb_adr == FR_ADR) begin
        fr_starts++;
        last_fr_start = cyc_n;
      end
    end else if (!hold_ack) begin
      checks++;
      if (wb_adr !== start_adr || wb_sel !== 4'hf || wb_stb !== 1'b1) begin
        errors++;
        $display("FAIL bus_hold: adr=%h sel=%h stb=%b, required adr=%h sel=f stb=1", wb_adr, wb_sel, wb_stb, start_adr);
      end
      if (wb_adr == FR_ADR && !wb_we) begin
        wb_dat_i = {24'h0, fr_val};
        fr_reads++;
        fr_ack_cycle = cyc_n;
        wb_ack = 1'b1;
      end else if (wb_adr == BASE && wb_we) begin
        dr_writes++;
        dr_wr_cycle = cyc_n;
        wr_tx_ready = tx_ready;
        op_log.push_back("T");
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL dr_write_unexpected: dat=%h, no write expected", wb_dat_o);
        end else begin
          mon_exp = exp_wr.pop_front();
          if (wb_dat_o !== {24'h0, mon_exp}) begin
            errors++;
            $display("FAIL dr_write_data: dat=%h, required %h", wb_dat_o, {24'h0, mon_exp});
          end
        end
        if (err_next_wr) begin
          err_next_wr = 1'b0;
          wb_err = 1'b1;
        end else begin
          wb_ack = 1'b1;
        end
      end else if (wb_adr == BASE && !wb_we) begin
        dr_reads++;
        op_log.push_back("R");
        wb_dat_i = dr_val;
        wb_ack = 1'b1;
      end else begin
        checks++;
        errors++;
        $display("FAIL bad_access: adr=%h we=%b, required DR or FR", wb_adr, wb_we);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    exp_wr.push_back(b);
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL send_accept: byte %h not accepted in %0d cycles, required acceptance", b, n);
    end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0;
    repeat (3) @(negedge clk);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b required 1", tx_ready); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b required 0", rx_valid); end
    checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin errors++; $display("FAIL reset_cyc: cyc=%b stb=%b required 0", wb_cyc, wb_stb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b required 0", error); end
    checks++; if (wb_adr !== 32'h0 || wb_we !== 1'b0 || wb_sel !== 4'h0) begin errors++; $display("FAIL reset_bus: adr=%h we=%b sel=%h required 0", wb_adr, wb_we, wb_sel); end
    rst = 1'b0;
  endtask

  task automatic test_idle_poll();
    int n, f0, s0, w0, r0, a;
    w0 = dr_writes; r0 = dr_reads; f0 = fr_reads;
    n = 0;
    while (fr_reads == f0 && n < 200) begin @(negedge clk); n++; end
    a = fr_ack_cycle;
    s0 = fr_starts;
    n = 0;
    while (fr_starts == s0 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n >= 200 || last_fr_start - (a + 1) != POLL_GAP + 1) begin
      errors++;
      $display("FAIL idle_poll_gap: next poll %0d cycles after DECIDE, required %0d", last_fr_start - (a + 1), POLL_GAP + 1);
    end
    checks++; if (dr_writes != w0 || dr_reads != r0) begin errors++; $display("FAIL idle_no_dr: wr=%0d rd=%0d required 0", dr_writes - w0, dr_reads - r0); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL idle_tx_ready: got %b required 1", tx_ready); end
  endtask

  task automatic test_tx_single();
    int n, w0, a;
    w0 = dr_writes;
    fr_val = 8'h90;
    send_byte(8'h41);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL tx_ready_after_accept: got %b required 0", tx_ready); end
    n = 0;
    while (dr_writes == w0 && n < 300) begin @(negedge clk); n++; end
    a = dr_wr_cycle;
    while (cyc_n < a + 1) @(negedge clk);
    checks++; if (wr_tx_ready !== 1'b0) begin errors++; $display("FAIL tx_ready_at_ack: got %b required 0", wr_tx_ready); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx_ready_after_ack: got %b required 1", tx_ready); end
    repeat (60) @(negedge clk);
    checks++; if (dr_writes - w0 != 1) begin errors++; $display("FAIL tx_single_count: %0d writes required 1", dr_writes - w0); end
  endtask

  task automatic test_tx_full();
    int n, w0, f0;
    fr_val = 8'hB0;
    w0 = dr_writes; f0 = fr_reads;
    send_byte(8'h55);
    repeat (120) @(negedge clk);
    checks++; if (dr_writes != w0) begin errors++; $display("FAIL txff_no_write: %0d writes required 0", dr_writes - w0); end
    checks++; if (fr_reads - f0 < 3) begin errors++; $display("FAIL txff_polls: %0d polls required at least 3", fr_reads - f0); end
    fr_val = 8'h90;
    n = 0;
    while (dr_writes == w0 && n < 200) begin @(negedge clk); n++; end
    repeat (60) @(negedge clk);
    checks++; if (dr_writes - w0 != 1) begin errors++; $display("FAIL txff_release_count: %0d writes required 1", dr_writes - w0); end
    checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL txff_pending: %0d writes outstanding required 0", exp_wr.size()); end
  endtask

  task automatic test_rx();
    int n, r0;
    logic [7:0] e;
    r0 = dr_reads;
    rx_ready = 1'b0;
    dr_val = 32'h0000_A57A;
    exp_rx.push_back(8'h7A);
    fr_val = 8'h80;
    n = 0;
    while (rx_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    e = exp_rx.pop_front();
    checks++; if (rx_valid !== 1'b1 || rx_data !== e) begin errors++; $display("FAIL rx_data: valid=%b data=%h required 1/%h", rx_valid, rx_data, e); end
    repeat (80) @(negedge clk);
    checks++; if (dr_reads - r0 != 1) begin errors++; $display("FAIL rx_backpressure: %0d reads required 1", dr_reads - r0); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rx_hold: valid=%b required 1", rx_valid); end
    fr_val = 8'h90;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_consume: valid=%b required 0", rx_valid); end
  endtask

  task automatic test_error();
    int n, w0;
    fr_val = 8'h90;
    w0 = dr_writes;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL error_before: got %b required 0", error); end
    err_next_wr = 1'b1;
    exp_wr.push_back(8'h33);
    send_byte(8'h33);
    n = 0;
    while (dr_writes - w0 < 2 && n < 400) begin @(negedge clk); n++; end
    checks++; if (dr_writes - w0 != 2) begin errors++; $display("FAIL err_resend: %0d write attempts required 2", dr_writes - w0); end
    repeat (2) @(negedge clk);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", error); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL err_tx_ready: got %b required 1", tx_ready); end
    checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL err_pending: %0d writes outstanding required 0", exp_wr.size()); end
  endtask

  task automatic test_alternate();
    int n;
    @(negedge clk);
    rst = 1'b1;
    fr_val = 8'h80;
    dr_val = 32'h0000_005C;
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    op_log.delete();
    rst = 1'b0;
    send_byte(8'hA1);
    send_byte(8'hB2);
    n = 0;
    while (op_log.size() < 3 && n < 300) begin @(negedge clk); n++; end
    fr_val = 8'h90;
    checks++;
    if (op_log.size() < 3 || op_log[0] != "T" || op_log[1] != "R" || op_log[2] != "T") begin
      errors++;
      $display("FAIL alternate_order: %0d ops logged, first=%s,%s,%s required T,R,T", op_log.size(),
               op_log.size() > 0 ? op_log[0] : "-", op_log.size() > 1 ? op_log[1] : "-", op_log.size() > 2 ? op_log[2] : "-");
    end
    repeat (60) @(negedge clk);
    rx_ready = 1'b0;
    checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL alternate_pending: %0d writes outstanding required 0", exp_wr.size()); end
  endtask

  task automatic test_timeout();
`ifdef UART_WBM_TIMEOUT_EN
    int k, d;
    @(negedge clk);
    rst = 1'b1;
    fr_val = 8'h90;
    repeat (2) @(negedge clk);
    hold_ack = 1'b1;
    rst = 1'b0;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL timeout_error_before: got %b required 0", error); end
    k = 0;
    while (!wb_cyc && k < 50) begin @(negedge clk); k++; end
    d = 0;
    while (wb_cyc && d < TIMEOUT + 50) begin d++; @(negedge clk); end
    checks++; if (d != TIMEOUT) begin errors++; $display("FAIL timeout_length: cyc held %0d cycles required %0d", d, TIMEOUT); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b required 1", error); end
    hold_ack = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_idle_poll();
    test_tx_single();
    test_tx_full();
    test_rx();
    test_error();
    test_alternate();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_wb_master.md
Name: uart_wb_master

Overview:
- Wishbone master that sits directly upstream of the Amber UART slave and drives its register interface.
- Converts a local byte stream (valid/ready) into DR writes, and converts received bytes into a local byte stream via DR reads.
- Polls the UART FR register to respect TX-full and RX-empty flags, giving firmware-free console I/O (boot loader, debug monitor).
- Single outstanding Wishbone cycle at a time; classic (non-pipelined) handshake.

Parameters:
- UART_BASE, 32'h1600_0000, base address of the target UART; DR = base+0x000, FR = base+0x018.
- POLL_GAP, 16, idle cycles between consecutive FR polls when the previous poll found no work (1..65535).
- TIMEOUT, 256, cycles without ack before a cycle is aborted (used only with UART_WBM_TIMEOUT_EN).

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  asynchronous active-high reset
- i_tx_valid  in  1  TX byte offered
- i_tx_data  in  8  TX byte
- o_tx_ready  out  1  TX holding register empty; byte accepted when valid&&ready
- o_rx_valid  out  1  RX byte available
- o_rx_data  out  8  RX byte
- i_rx_ready  in  1  consumer takes RX byte when valid&&ready
- o_wb_adr  out  32  Wishbone address
- o_wb_sel  out  4  byte selects, always 4'hf during a cycle
- o_wb_we  out  1  write enable
- o_wb_dat  out  32  write data, {24'h0, byte}
- i_wb_dat  in  32  read data
- o_wb_cyc  out  1  cycle
- o_wb_stb  out  1  strobe (equal to o_wb_cyc)
- i_wb_ack  in  1  acknowledge
- i_wb_err  in  1  error termination
- o_busy  out  1  FSM not in IDLE
- o_error  out  1  sticky: set on i_wb_err (or timeout); cleared only by reset

Behaviour:
- Interface: one clock, i_clk; reset i_rst is asynchronous, active-high.
- Reset values: all outputs 0, except o_tx_ready=1. FSM enters IDLE, poll counter = 0, tx_hold and rx_hold invalid, last_op = RX.
- TX holding register (1 entry): loaded on i_tx_valid && o_tx_ready. o_tx_ready = !tx_hold_valid (registered).
- RX holding register (1 entry): o_rx_valid drops the cycle after the consumer handshake.
- FSM states: IDLE, FR_RD, DECIDE, DR_WR, DR_RD.
- IDLE: poll counter counts down. At 0, if (tx_hold_valid || !o_rx_valid), go to FR_RD.
- FR_RD: assert cyc/stb, adr=UART_BASE+0x18, we=0. On ack, capture fr=i_wb_dat[7:0] and drop cyc/stb the same edge; go to DECIDE.
- DECIDE (1 cycle): tx_ok = tx_hold_valid && !fr[5] (TXFF); rx_ok = !o_rx_valid && !fr[4] (RXFE).
  - Both ok: alternate, choosing the op opposite to last_op.
  - Only one ok: choose it.
  - Neither: load poll counter = POLL_GAP, go to IDLE.
- DR_WR: cyc/stb/we=1, adr=UART_BASE, dat={24'h0,tx_hold}. On ack: tx_hold invalid (o_tx_ready=1 next cycle), last_op=TX, go to FR_RD immediately (no gap).
- DR_RD: cyc/stb=1, we=0, adr=UART_BASE. On ack: rx_hold=i_wb_dat[7:0], o_rx_valid=1, last_op=RX, go to FR_RD.
- Wishbone timing:
  - Outputs are registered and stable from assertion until the ack cycle.
  - cyc/stb deassert the cycle after ack; a new cycle never starts in the same cycle as an ack.
  - Minimum two cycles per access against the Amber UART's registered ack.
- i_wb_err during any cycle: treated as ack without data effect. o_error=1, TX byte retained, RX not updated, go to IDLE with counter=POLL_GAP.
- A byte offered while a DR_WR of the previous byte is in flight is not accepted until that ack.
- Reset mid-cycle: cyc/stb drop asynchronously; held bytes are lost.
- Poll counter: 16-bit saturating down-counter, never wraps.

Optional Feature:
- Macro UART_WBM_TIMEOUT_EN.
- Defined: a counter runs while cyc=1. On reaching TIMEOUT without ack or err, the cycle is aborted (cyc/stb=0 next edge), o_error=1, and the FSM takes the i_wb_err path.
- Undefined: no counter; the FSM waits for ack indefinitely.

Test Plan:
- Reset then idle, FR read returns 8'h90 (TXFE, RXFE) → after FR read, no DR access; next FR read starts exactly POLL_GAP+1 cycles after DECIDE; o_tx_ready=1.
- Send 8'h41, FR=8'h90 → one write at UART_BASE, dat=32'h41, sel=4'hf; o_tx_ready low from accept to ack+1.
- FR=8'hB0 (TXFF) with pending 8'h55 → no DR write; repeated polls; after FR becomes 8'h90, write 8'h55 occurs exactly once.
- FR=8'h80, DR returns 32'h7A, i_rx_ready=0 → o_rx_valid=1, o_rx_data=8'h7A; no further DR reads until consumer takes it.
- TX pending and RX available on the same poll, three times → accesses alternate TX/RX/TX, starting with TX after reset.
- i_wb_err on DR write of 8'h33 → o_error=1, byte resent after next poll. With UART_WBM_TIMEOUT_EN and ack withheld → abort at TIMEOUT cycles, o_error=1.
